// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl
//   Reads a combinational instruction ROM from an internal PC. Each word is
//   captured with its PC in a small prefetch FIFO. The FIFO head is offered
//   to decode through a valid/ready handshake. A redirect flushes the FIFO
//   and reloads the PC.
//
//   Optional build macro: FETCH_PERF_CNT_EN adds the perf_fetch_cnt_o and
//   perf_stall_cnt_o outputs.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   fetch_en_i        1 = ROM reads allowed
//   rom_ce_o          ROM read enable
//   rom_addr_o        ROM byte address (0 when not reading)
//   rom_inst_i        ROM data, valid in the same cycle as rom_ce_o
//   redirect_valid_i  one-cycle PC change request
//   redirect_pc_i     redirect target (bits [1:0] ignored)
//   id_valid_o        FIFO head valid
//   id_ready_i        decode accepts the head
//   id_inst_o         head instruction (0 when empty)
//   id_pc_o           head PC (0 when empty)
//   fifo_count_o      FIFO occupancy
//   perf_fetch_cnt_o  committed pushes          (FETCH_PERF_CNT_EN only)
//   perf_stall_cnt_o  cycles stalled on full    (FETCH_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter int unsigned              ADDR_W     = 32,
  parameter int unsigned              INST_W     = 32,
  parameter int unsigned              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]        RESET_PC   = {ADDR_W{1'b0}}
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         fetch_en_i,
  output logic                         rom_ce_o,
  output logic [ADDR_W-1:0]            rom_addr_o,
  input  logic [INST_W-1:0]            rom_inst_i,
  input  logic                         redirect_valid_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  output logic                         id_valid_o,
  input  logic                         id_ready_i,
  output logic [INST_W-1:0]            id_inst_o,
  output logic [ADDR_W-1:0]            id_pc_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_fetch_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MSK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];

  logic                  id_valid_s;
  logic                  pop_s;
  logic                  can_push_s;
  logic                  push_s;
  logic                  commit_s;
  logic [ENT_W-1:0]      head_s;

  // Handshake decode, next-state and pointer arithmetic.
  always_comb begin
    id_valid_s = (count_q != {CNT_W{1'b0}});
    pop_s      = id_valid_s && id_ready_i;
    // A pop on the same edge frees the slot a full FIFO needs.
    can_push_s = (count_q < CNT_FULL) || pop_s;
    push_s     = (state_q == FETCH) && can_push_s;
    // A read made during the redirect cycle belongs to the old path.
    commit_s   = push_s && !redirect_valid_i;

    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    case (state_q)
      IDLE:    state_d = fetch_en_i ? FETCH : IDLE;
      FETCH:   state_d = fetch_en_i ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i & ALIGN_MSK;
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_d     = pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        pc_d     = pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: FSM, PC, FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage: each entry holds {pc, instruction}.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
    end else if (commit_s) begin
      mem_q[wr_ptr_q] <= {pc_q, rom_inst_i};
    end
  end

  assign head_s       = id_valid_s ? mem_q[rd_ptr_q] : {ENT_W{1'b0}};
  assign id_valid_o   = id_valid_s;
  assign id_pc_o      = head_s[ENT_W-1:INST_W];
  assign id_inst_o    = head_s[INST_W-1:0];
  assign fifo_count_o = count_q;
  assign rom_ce_o     = push_s;
  assign rom_addr_o   = push_s ? pc_q : {ADDR_W{1'b0}};

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Performance counters: committed pushes and full-FIFO stall cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (commit_s) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if ((state_q == FETCH) && fetch_en_i && !can_push_s) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Directed bench for inst_fetch_ctrl. Each ROM returns its own address as
//   the instruction word. dut runs from RESET_PC 0. dut2 free-runs from
//   FFFF_FFF8 to cover PC wrap-around.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [2:0]  fifo_count;

  logic        rom_ce2;
  logic [31:0] rom_addr2;
  logic [31:0] rom_inst2;
  logic        id_valid2;
  logic [31:0] id_inst2;
  logic [31:0] id_pc2;
  logic [2:0]  fifo_count2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf1, ps1, pf2, ps2;
`endif

  int n_vec = 0;
  int n_err = 0;

  assign rom_inst  = rom_addr;
  assign rom_inst2 = rom_addr2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_ready_i(id_ready), .id_inst_o(id_inst),
    .id_pc_o(id_pc), .fifo_count_o(fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(pf1), .perf_stall_cnt_o(ps1)
`endif
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(1'b1),
    .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2), .rom_inst_i(rom_inst2),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .id_valid_o(id_valid2), .id_ready_i(1'b1), .id_inst_o(id_inst2),
    .id_pc_o(id_pc2), .fifo_count_o(fifo_count2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(pf2), .perf_stall_cnt_o(ps2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    #1;
    chk("rst_rom_ce",   {31'd0, rom_ce},     32'd0);
    chk("rst_rom_addr", rom_addr,            32'd0);
    chk("rst_id_valid", {31'd0, id_valid},   32'd0);
    chk("rst_id_pc",    id_pc,               32'd0);
    chk("rst_id_inst",  id_inst,             32'd0);
    chk("rst_count",    {29'd0, fifo_count}, 32'd0);
    tick(); tick();

    // Release; the first edge enters FETCH and the second pushes.
    rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
    tick(); #1;
    chk("e1_id_valid", {31'd0, id_valid}, 32'd0);
    chk("e1_rom_ce",   {31'd0, rom_ce},   32'd1);
    chk("e1_rom_addr", rom_addr,          32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("stream_id_valid", {31'd0, id_valid}, 32'd1);
      chk("stream_id_pc",    id_pc,   32'(4 * k));
      chk("stream_id_inst",  id_inst, 32'(4 * k));
      chk("stream_rom_addr", rom_addr, 32'(4 * k + 4));
      chk("wrap_id_pc",      id_pc2,  32'hFFFF_FFF8 + 32'(4 * k));
    end

    // Head is 8 and the PC is 12. Stall decode until the FIFO fills.
    id_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #1;
    chk("full_count",    {29'd0, fifo_count}, 32'd4);
    chk("full_rom_ce",   {31'd0, rom_ce},     32'd0);
    chk("full_rom_addr", rom_addr,            32'd0);
    chk("full_id_pc",    id_pc,               32'h8);

    // A full FIFO with ready high pushes and pops on the same edge.
    id_ready = 1'b1; #1;
    chk("fullpop_rom_ce",   {31'd0, rom_ce}, 32'd1);
    chk("fullpop_rom_addr", rom_addr,        32'd24);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("fullpop_count", {29'd0, fifo_count}, 32'd4);
      chk("fullpop_id_pc", id_pc, 32'(12 + 4 * k));
    end

    // Redirect to 0x103; the target is forced to 0x100.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0000_0000; #1;
    chk("redir_count",    {29'd0, fifo_count}, 32'd0);
    chk("redir_id_valid", {31'd0, id_valid},   32'd0);
    chk("redir_rom_addr", rom_addr,            32'h100);
    tick(); #1;
    chk("redir_id_pc",   id_pc,   32'h100);
    chk("redir_id_inst", id_inst, 32'h100);
    tick(); #1;
    chk("redir_next_pc", id_pc, 32'h104);

    // Drop fetch_en: the push on this edge still completes.
    fetch_en = 1'b0; id_ready = 1'b0;
    tick(); #1;
    chk("halt_count",  {29'd0, fifo_count}, 32'd2);
    chk("halt_rom_ce", {31'd0, rom_ce},     32'd0);
    chk("halt_id_pc",  id_pc,               32'h104);
    tick(); #1;
    chk("halt_hold", {29'd0, fifo_count}, 32'd2);
    id_ready = 1'b1;
    tick(); #1;
    chk("drain_id_pc", id_pc,               32'h108);
    chk("drain_count", {29'd0, fifo_count}, 32'd1);
    tick(); #1;
    chk("empty_id_valid", {31'd0, id_valid}, 32'd0);
    chk("empty_id_pc",    id_pc,             32'd0);
    chk("empty_id_inst",  id_inst,           32'd0);

    // Fill the FIFO again, then apply an asynchronous reset between edges.
    fetch_en = 1'b1; id_ready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    #1;
    chk("refill_count", {29'd0, fifo_count}, 32'd4);
    #2;
    rst_n = 1'b0; #1;
    chk("arst_id_valid", {31'd0, id_valid},   32'd0);
    chk("arst_rom_ce",   {31'd0, rom_ce},     32'd0);
    chk("arst_count",    {29'd0, fifo_count}, 32'd0);
    tick();
    rst_n = 1'b1; id_ready = 1'b1;
    tick(); #1;
    chk("restart_rom_addr", rom_addr, 32'd0);
    chk("restart_rom_ce",   {31'd0, rom_ce}, 32'd1);
    tick(); #1;
    chk("restart_id_pc", id_pc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
